// File: rtl/rf_pkg.sv
// Shared types for the integer register file and load-return extract path.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rf_pkg;

  typedef enum logic [1:0] {
    LD_B = 2'b00,
    LD_H = 2'b01,
    LD_W = 2'b10,
    LD_D = 2'b11
  } ld_size_e;

  function automatic int rf_addr_w(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/load_ext.sv
// Load-return extract: shift the bus-aligned datum down, take the sub-word, extend to XLEN.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the result is valid whenever the inputs are.
module load_ext
  import rf_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int BW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] lr_data,
  input  logic [BW-1:0]   lr_boff,
  input  logic [1:0]      lr_size,
  input  logic            lr_uns,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext_b;
  logic [XLEN-1:0] ext_h;
  logic [XLEN-1:0] ext_w;

  // Misaligned offsets are not trapped: whatever lands in the low bits is used.
  assign shifted = lr_data >> {lr_boff, 3'b000};
  assign ext_b   = {{(XLEN-8){shifted[7] & ~lr_uns}}, shifted[7:0]};
  assign ext_h   = {{(XLEN-16){shifted[15] & ~lr_uns}}, shifted[15:0]};

  generate
    if (XLEN > 32) begin : g_w_ext
      assign ext_w = {{(XLEN-32){shifted[31] & ~lr_uns}}, shifted[31:0]};
    end else begin : g_w_full
      assign ext_w = shifted;
    end
  endgenerate

  always_comb begin
    result = shifted;
    case (ld_size_e'(lr_size))
      LD_B:    result = ext_b;
      LD_H:    result = ext_h;
      LD_W:    result = ext_w;
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-first bypassed read ports and a load busy scoreboard.
// Latency: reads 0 cycles (combinational); writes and busy updates land on the next rising edge.
// Backpressure: none; ld_ready_o tells issue whether the load destination is free.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW = rf_addr_w(NREGS),
  localparam int BW = $clog2(XLEN / 8)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREAD*AW-1:0]   rd_addr_i,
  output logic [NREAD*XLEN-1:0] rd_data_o,
  output logic [NREAD-1:0]      rd_busy_o,
  input  logic                  wa_en_i,
  input  logic [AW-1:0]         wa_addr_i,
  input  logic [XLEN-1:0]       wa_data_i,
  input  logic                  ld_issue_i,
  input  logic [AW-1:0]         ld_rd_i,
  output logic                  ld_ready_o,
  input  logic                  lr_valid_i,
  input  logic [AW-1:0]         lr_addr_i,
  input  logic [1:0]            lr_size_i,
  input  logic                  lr_uns_i,
  input  logic [BW-1:0]         lr_boff_i,
  input  logic [XLEN-1:0]       lr_data_i,
  output logic                  collide_o
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [XLEN-1:0]  ld_val;
  logic             lr_hit;
  logic             wa_hit;
  logic             same_dst;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .lr_data (lr_data_i),
    .lr_boff (lr_boff_i),
    .lr_size (lr_size_i),
    .lr_uns  (lr_uns_i),
    .result  (ld_val)
  );

  assign lr_hit   = lr_valid_i && (lr_addr_i != '0);
  assign same_dst = wa_en_i && lr_hit && (wa_addr_i == lr_addr_i);
  // The load return owns the register when both ports target it.
  assign wa_hit   = wa_en_i && (wa_addr_i != '0) && !same_dst;

  always_comb begin
    busy_nxt = busy;
    if (lr_valid_i) begin
      busy_nxt[lr_addr_i] = 1'b0;
    end
    if (ld_issue_i && (ld_rd_i != '0)) begin
      busy_nxt[ld_rd_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
      busy      <= '0;
      collide_o <= 1'b0;
    end else begin
      if (wa_hit) begin
        regs[wa_addr_i] <= wa_data_i;
      end
      if (lr_hit) begin
        regs[lr_addr_i] <= ld_val;
      end
      busy <= busy_nxt;
      if (same_dst) begin
        collide_o <= 1'b1;
      end
    end
  end

  assign ld_ready_o = ~busy[ld_rd_i];

  generate
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            lr_byp;
      logic            wa_byp;

      assign addr = rd_addr_i[k*AW +: AW];

      // Bypass is suppressed in reset so reads show the (cleared) array contents.
      always_comb begin
        lr_byp = !rst_i && lr_hit && (lr_addr_i == addr);
        wa_byp = !rst_i && wa_en_i && (wa_addr_i == addr);
        if (addr == '0) begin
          data = '0;
        end else if (lr_byp) begin
          data = ld_val;
        end else if (wa_byp) begin
          data = wa_data_i;
        end else begin
          data = regs[addr];
        end
      end

      assign rd_data_o[k*XLEN +: XLEN] = data;
      assign rd_busy_o[k]              = busy[addr] & ~lr_byp;
    end
  endgenerate

`ifndef SYNTHESIS
  a_issue_not_busy: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (ld_issue_i && (ld_rd_i != '0)) |-> !busy[ld_rd_i]
  );
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: 32-bit/32-reg/2-port and 64-bit/16-reg/3-port instances.
// Expectations are queued at stimulus time and drained by a separate monitor.
module tb_regfile_sb;

  typedef struct packed {
    logic [2:0][4:0] ra;
    logic            wa_en;
    logic [4:0]      wa_addr;
    logic [63:0]     wa_data;
    logic            ld_issue;
    logic [4:0]      ld_rd;
    logic            lr_valid;
    logic [4:0]      lr_addr;
    logic [1:0]      lr_size;
    logic            lr_uns;
    logic [2:0]      lr_boff;
    logic [63:0]     lr_data;
  } stim_t;

  typedef struct {
    int          dut;
    int          kind;
    int          port;
    logic [63:0] exp;
    string       name;
  } exp_t;

  localparam int K_DATA = 0, K_BUSY = 1, K_READY = 2, K_COLL = 3;

  logic  clk = 1'b0;
  logic  rst;
  stim_t st [2];
  exp_t  sbq [$];
  int    total = 0;
  int    bad = 0;

  int xl [2] = '{32, 64};
  int nr [2] = '{32, 16};
  int np [2] = '{2, 3};

  logic [63:0] m_reg  [2][32];
  logic        m_busy [2][32];
  logic        m_coll [2];

  always #5 clk = ~clk;

  logic [63:0]  rd_data0;
  logic [1:0]   rd_busy0;
  logic         ld_ready0, collide0;
  logic [191:0] rd_data1;
  logic [2:0]   rd_busy1;
  logic         ld_ready1, collide1;

  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .rd_addr_i({st[0].ra[1], st[0].ra[0]}),
    .rd_data_o(rd_data0), .rd_busy_o(rd_busy0),
    .wa_en_i(st[0].wa_en), .wa_addr_i(st[0].wa_addr), .wa_data_i(st[0].wa_data[31:0]),
    .ld_issue_i(st[0].ld_issue), .ld_rd_i(st[0].ld_rd), .ld_ready_o(ld_ready0),
    .lr_valid_i(st[0].lr_valid), .lr_addr_i(st[0].lr_addr), .lr_size_i(st[0].lr_size),
    .lr_uns_i(st[0].lr_uns), .lr_boff_i(st[0].lr_boff[1:0]), .lr_data_i(st[0].lr_data[31:0]),
    .collide_o(collide0)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .NREAD(3)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .rd_addr_i({st[1].ra[2][3:0], st[1].ra[1][3:0], st[1].ra[0][3:0]}),
    .rd_data_o(rd_data1), .rd_busy_o(rd_busy1),
    .wa_en_i(st[1].wa_en), .wa_addr_i(st[1].wa_addr[3:0]), .wa_data_i(st[1].wa_data),
    .ld_issue_i(st[1].ld_issue), .ld_rd_i(st[1].ld_rd[3:0]), .ld_ready_o(ld_ready1),
    .lr_valid_i(st[1].lr_valid), .lr_addr_i(st[1].lr_addr[3:0]), .lr_size_i(st[1].lr_size),
    .lr_uns_i(st[1].lr_uns), .lr_boff_i(st[1].lr_boff), .lr_data_i(st[1].lr_data),
    .collide_o(collide1)
  );

  // Reference extract: plain shift/modulo arithmetic on a 64-bit value.
  function automatic logic [63:0] ref_ext(input int xlen, input logic [63:0] data,
                                          input int boff, input int size, input bit uns);
    logic [63:0] v;
    logic [63:0] lim;
    int          nbits;
    v = (xlen == 32) ? (data & 64'hFFFF_FFFF) : data;
    v = v >> (8 * boff);
    nbits = 8 << size;
    if (nbits > xlen) nbits = xlen;
    if (nbits < 64) begin
      lim = 64'd1 << nbits;
      v = v % lim;
      if (!uns && v >= (lim >> 1)) v = v - lim;
    end
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  function automatic logic [63:0] xmask(input int d, input logic [63:0] v);
    return (d == 0) ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  function automatic logic [63:0] actual(input int d, input int kind, input int p);
    if (d == 0) begin
      case (kind)
        K_DATA:  return {32'd0, rd_data0[p*32 +: 32]};
        K_BUSY:  return {63'd0, rd_busy0[p]};
        K_READY: return {63'd0, ld_ready0};
        default: return {63'd0, collide0};
      endcase
    end else begin
      case (kind)
        K_DATA:  return rd_data1[p*64 +: 64];
        K_BUSY:  return {63'd0, rd_busy1[p]};
        K_READY: return {63'd0, ld_ready1};
        default: return {63'd0, collide1};
      endcase
    end
  endfunction

  task automatic exp_c(input int d, input int kind, input int p, input logic [63:0] v, input string n);
    exp_t e;
    e.dut = d; e.kind = kind; e.port = p; e.exp = v; e.name = n;
    sbq.push_back(e);
  endtask

  task automatic push_model();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < np[d]; p++) begin
        int          a;
        bit          lrh;
        logic [63:0] ed;
        a   = int'(st[d].ra[p]);
        lrh = !rst && st[d].lr_valid && int'(st[d].lr_addr) == a;
        if (a == 0) ed = '0;
        else if (lrh) ed = ref_ext(xl[d], st[d].lr_data, int'(st[d].lr_boff), int'(st[d].lr_size), st[d].lr_uns);
        else if (!rst && st[d].wa_en && int'(st[d].wa_addr) == a) ed = xmask(d, st[d].wa_data);
        else ed = m_reg[d][a];
        exp_c(d, K_DATA, p, ed, $sformatf("d%0d_rd%0d_data", d, p));
        exp_c(d, K_BUSY, p, {63'd0, (a != 0) && m_busy[d][a] && !lrh}, $sformatf("d%0d_rd%0d_busy", d, p));
      end
      exp_c(d, K_READY, 0, {63'd0, !m_busy[d][st[d].ld_rd]}, $sformatf("d%0d_ld_ready", d));
      exp_c(d, K_COLL, 0, {63'd0, m_coll[d]}, $sformatf("d%0d_collide", d));
    end
  endtask

  task automatic update_model();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          m_reg[d][r]  = '0;
          m_busy[d][r] = 1'b0;
        end
        m_coll[d] = 1'b0;
      end else begin
        bit lrw, waw, same;
        lrw  = st[d].lr_valid && st[d].lr_addr != 0;
        waw  = st[d].wa_en && st[d].wa_addr != 0;
        same = lrw && waw && st[d].lr_addr == st[d].wa_addr;
        if (same) m_coll[d] = 1'b1;
        if (waw && !same) m_reg[d][st[d].wa_addr] = xmask(d, st[d].wa_data);
        if (lrw) m_reg[d][st[d].lr_addr] = ref_ext(xl[d], st[d].lr_data, int'(st[d].lr_boff),
                                                   int'(st[d].lr_size), st[d].lr_uns);
        if (st[d].lr_valid) m_busy[d][st[d].lr_addr] = 1'b0;
        if (st[d].ld_issue && st[d].ld_rd != 0) m_busy[d][st[d].ld_rd] = 1'b1;
      end
    end
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic step();
    push_model();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic idle();
    st[0] = '0;
    st[1] = '0;
  endtask

  task automatic lr_set(input int d, input int a, input logic [63:0] data,
                        input int boff, input int size, input bit uns);
    st[d].lr_valid = 1'b1;
    st[d].lr_addr  = 5'(a);
    st[d].lr_data  = data;
    st[d].lr_boff  = 3'(boff);
    st[d].lr_size  = 2'(size);
    st[d].lr_uns   = uns;
  endtask

  task automatic rand_stim();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 3; p++) begin
        st[d].ra[p] = (p < np[d]) ? 5'($urandom_range(0, nr[d] - 1)) : 5'd0;
      end
      st[d].wa_en    = 1'($urandom_range(0, 1));
      st[d].wa_addr  = 5'($urandom_range(0, nr[d] - 1));
      st[d].wa_data  = {$urandom, $urandom};
      st[d].ld_rd    = 5'($urandom_range(0, nr[d] - 1));
      st[d].ld_issue = ($urandom_range(0, 2) == 0) && !m_busy[d][st[d].ld_rd];
      st[d].lr_valid = ($urandom_range(0, 2) == 0);
      st[d].lr_addr  = ($urandom_range(0, 3) == 0) ? st[d].wa_addr : 5'($urandom_range(0, nr[d] - 1));
      st[d].lr_size  = 2'($urandom_range(0, 3));
      st[d].lr_uns   = 1'($urandom_range(0, 1));
      st[d].lr_boff  = 3'($urandom_range(0, xl[d] / 8 - 1));
      st[d].lr_data  = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) st[d].ra[0] = st[d].lr_addr;
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      while (sbq.size() > 0) begin
        exp_t        e;
        logic [63:0] a;
        e = sbq.pop_front();
        a = actual(e.dut, e.kind, e.port);
        total++;
        if (a !== e.exp) begin
          bad++;
          $display("FAIL %s: got %h want %h at %0t", e.name, a, e.exp, $time);
        end
      end
    end
  end

  initial begin : driver
    rst = 1'b1;
    idle();
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    repeat (20) begin
      rand_stim();
      step();
    end
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    for (int r = 0; r < 16; r++) begin
      idle();
      st[0].ra[0] = 5'(r);
      st[0].ra[1] = 5'(r + 16);
      st[1].ra[0] = 5'(r);
      exp_c(0, K_DATA, 0, 64'd0, "rst_rd_lo");
      exp_c(0, K_DATA, 1, 64'd0, "rst_rd_hi");
      exp_c(0, K_BUSY, 1, 64'd0, "rst_busy");
      exp_c(1, K_DATA, 0, 64'd0, "rst_rd_d64");
      exp_c(0, K_COLL, 0, 64'd0, "rst_collide");
      step();
    end

    idle(); st[0].wa_en = 1; st[0].wa_addr = 5; st[0].wa_data = 64'hDEAD_BEEF; st[0].ra[0] = 5;
    exp_c(0, K_DATA, 0, 64'hDEAD_BEEF, "wa_bypass");
    step();
    idle(); st[0].ra[0] = 5;
    exp_c(0, K_DATA, 0, 64'hDEAD_BEEF, "wa_stored");
    step();
    idle(); st[0].wa_en = 1; st[0].wa_addr = 0; st[0].wa_data = 64'd1; st[0].ra[0] = 0;
    exp_c(0, K_DATA, 0, 64'd0, "x0_write_same_cycle");
    step();
    idle(); st[0].ra[0] = 0;
    exp_c(0, K_DATA, 0, 64'd0, "x0_reads_zero");
    step();

    idle(); lr_set(0, 10, 64'h80FF_7F01, 1, 0, 0); st[0].ra[0] = 10;
    exp_c(0, K_DATA, 0, 64'h0000_007F, "ext_b_signed_bypass");
    step();
    idle(); st[0].ra[0] = 10;
    exp_c(0, K_DATA, 0, 64'h0000_007F, "ext_b_signed_stored");
    step();
    idle(); lr_set(0, 11, 64'h80FF_7F01, 1, 0, 1); st[0].ra[0] = 11;
    exp_c(0, K_DATA, 0, 64'h0000_007F, "ext_b_unsigned");
    step();
    idle(); lr_set(0, 12, 64'h80FF_7F01, 2, 1, 0); st[0].ra[0] = 12;
    exp_c(0, K_DATA, 0, 64'hFFFF_80FF, "ext_h_signed");
    step();
    idle(); lr_set(0, 13, 64'h80FF_7F01, 2, 0, 0); st[0].ra[0] = 13;
    exp_c(0, K_DATA, 0, 64'hFFFF_FFFF, "ext_b_negative");
    step();
    idle(); lr_set(0, 14, 64'h80FF_7F01, 3, 0, 1); st[0].ra[0] = 14;
    exp_c(0, K_DATA, 0, 64'h0000_0080, "ext_b_top_uns");
    step();
    idle(); lr_set(0, 15, 64'h80FF_7F01, 0, 3, 0); st[0].ra[0] = 15;
    exp_c(0, K_DATA, 0, 64'h80FF_7F01, "ext_d_on_32");
    step();
    idle(); lr_set(0, 16, 64'h8000_0000, 0, 2, 0); st[0].ra[0] = 16;
    exp_c(0, K_DATA, 0, 64'h8000_0000, "ext_w_on_32");
    step();

    idle(); st[0].ld_issue = 1; st[0].ld_rd = 7; st[0].ra[0] = 7;
    exp_c(0, K_READY, 0, 64'd1, "issue_cycle_ready");
    step();
    for (int c = 1; c < 3; c++) begin
      idle(); st[0].ld_rd = 7; st[0].ra[0] = 7;
      exp_c(0, K_READY, 0, 64'd0, "ld_ready_busy");
      exp_c(0, K_BUSY, 0, 64'd1, "rd_busy_set");
      step();
    end
    idle(); lr_set(0, 7, 64'h1234, 0, 2, 0); st[0].ld_rd = 7; st[0].ra[0] = 7;
    exp_c(0, K_BUSY, 0, 64'd0, "return_clears_hazard");
    exp_c(0, K_DATA, 0, 64'h1234, "return_bypass_data");
    step();
    idle(); st[0].ld_rd = 7; st[0].ra[0] = 7;
    exp_c(0, K_READY, 0, 64'd1, "ld_ready_after_return");
    step();

    idle(); st[0].wa_en = 1; st[0].wa_addr = 9; st[0].wa_data = 64'd1;
    lr_set(0, 9, 64'd2, 0, 2, 0); st[0].ra[0] = 9;
    exp_c(0, K_DATA, 0, 64'd2, "collide_lr_wins_bypass");
    step();
    for (int c = 0; c < 3; c++) begin
      idle(); st[0].ra[0] = 9;
      exp_c(0, K_DATA, 0, 64'd2, "collide_lr_stored");
      exp_c(0, K_COLL, 0, 64'd1, "collide_sticky");
      step();
    end
    idle(); st[0].ld_issue = 1; st[0].ld_rd = 4; lr_set(0, 4, 64'd5, 0, 2, 0);
    step();
    idle(); st[0].ld_rd = 4; st[0].ra[0] = 4;
    exp_c(0, K_BUSY, 0, 64'd1, "issue_return_set_wins");
    exp_c(0, K_READY, 0, 64'd0, "issue_return_not_ready");
    step();
    idle(); lr_set(0, 4, 64'd6, 0, 2, 0);
    step();

    idle(); lr_set(1, 3, 64'h0123_4567_89AB_CDEF, 0, 3, 0);
    st[1].ra[0] = 3; st[1].ra[1] = 3;
    exp_c(1, K_DATA, 0, 64'h0123_4567_89AB_CDEF, "d64_passthrough");
    exp_c(1, K_DATA, 1, 64'h0123_4567_89AB_CDEF, "d64_passthrough_p1");
    step();
    idle(); lr_set(1, 5, 64'h8000_0000, 0, 2, 0); st[1].ra[2] = 5;
    exp_c(1, K_DATA, 2, 64'hFFFF_FFFF_8000_0000, "d64_w_signext");
    step();
    idle(); lr_set(1, 6, 64'h8000_0000, 0, 2, 1); st[1].ra[2] = 6;
    exp_c(1, K_DATA, 2, 64'h0000_0000_8000_0000, "d64_w_zeroext");
    step();

    repeat (400) begin
      rand_stim();
      step();
    end

    idle();
    #3;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
